// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Shares the single write port of the asynchronous FIFO between two
// requesters in the write (reference) clock domain:
//   - register-file read path: one byte per transfer
//   - ALU result path: one 2*DATA_WIDTH word, written low byte first
// The granted requester's data is captured into HOLD on grant, and one
// W_INC is issued per byte, never while FULL is high.
//
// Ports
//   CLK       in   write-domain clock, rising edge
//   RST       in   synchronous active-high reset
//   RF_REQ    in   register-file request, held until RF_ACK
//   RF_DATA   in   register-file byte, stable while RF_REQ is high
//   RF_ACK    out  one-cycle pulse: RF data captured
//   ALU_REQ   in   ALU request, held until ALU_ACK
//   ALU_DATA  in   ALU word, stable while ALU_REQ is high
//   ALU_ACK   out  one-cycle pulse: ALU data captured
//   FULL      in   FIFO full flag (write domain)
//   WR_DATA   out  FIFO write data, registered
//   W_INC     out  FIFO write strobe
//   BUSY      out  high whenever a transfer is in progress
//
// States
//   state | meaning
//   IDLE  | no transfer; requests sampled and arbitrated
//   WR_LO | low (or only) byte presented on WR_DATA, waiting for !FULL
//   WR_HI | ALU high byte presented on WR_DATA, waiting for !FULL

module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    RF_REQ,
    input  logic [DATA_WIDTH-1:0]   RF_DATA,
    output logic                    RF_ACK,
    input  logic                    ALU_REQ,
    input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
    output logic                    ALU_ACK,
    input  logic                    FULL,
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    W_INC,
    output logic                    BUSY
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WR_LO = 2'd1;
    localparam logic [1:0] WR_HI = 2'd2;

    logic [1:0]              state;
    logic [2*DATA_WIDTH-1:0] hold;
    logic                    last_gnt;   // 0 = RF, 1 = ALU
    logic                    gnt_rf;
    logic                    gnt_alu;

    // Round-robin on a tie: the requester that did not win last time.
    always_comb begin
        gnt_rf  = 1'b0;
        gnt_alu = 1'b0;
        if (state == IDLE) begin
            gnt_rf  = RF_REQ  && (!ALU_REQ || last_gnt);
            gnt_alu = ALU_REQ && (!RF_REQ  || !last_gnt);
        end
    end

    // Combinational on FULL so a full FIFO is never written; suppressed
    // during reset so an aborted transfer writes nothing more.
    assign W_INC = (state != IDLE) && !FULL && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            hold     <= '0;
            last_gnt <= 1'b1;
            WR_DATA  <= '0;
            RF_ACK   <= 1'b0;
            ALU_ACK  <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            RF_ACK  <= gnt_rf;
            ALU_ACK <= gnt_alu;
            case (state)
                IDLE: begin
                    if (gnt_alu) begin
                        hold     <= ALU_DATA;
                        WR_DATA  <= ALU_DATA[DATA_WIDTH-1:0];
                        last_gnt <= 1'b1;
                        state    <= WR_LO;
                        BUSY     <= 1'b1;
                    end else if (gnt_rf) begin
                        hold     <= {{DATA_WIDTH{1'b0}}, RF_DATA};
                        WR_DATA  <= RF_DATA;
                        last_gnt <= 1'b0;
                        state    <= WR_LO;
                        BUSY     <= 1'b1;
                    end
                end
                WR_LO: begin
                    if (W_INC) begin
                        if (last_gnt) begin
                            // ALU pair stays atomic: high byte follows directly.
                            WR_DATA <= hold[2*DATA_WIDTH-1:DATA_WIDTH];
                            state   <= WR_HI;
                        end else begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        // Stalled: keep presenting the captured low byte.
                        WR_DATA <= hold[DATA_WIDTH-1:0];
                    end
                end
                WR_HI: begin
                    if (W_INC) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
